// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and small helpers for the CNN lane-feature engine.
package cnn_pkg;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int POOL_W    = 15;
  localparam int PIX_W     = 8;
  localparam int CONV_W    = 11;
  localparam int FEAT_W    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sobel-X, indexed [window row][window col]; col 0 is the oldest (leftmost) pixel.
  localparam logic signed [CONV_W-1:0] SOBEL_X [3][3] = '{
    '{-11'sd1, 11'sd0, 11'sd1},
    '{-11'sd2, 11'sd0, 11'sd2},
    '{-11'sd1, 11'sd0, 11'sd1}
  };

  function automatic logic [FEAT_W-1:0] relu(input logic signed [CONV_W-1:0] v);
    return v[CONV_W-1] ? {FEAT_W{1'b0}} : v[FEAT_W-1:0];
  endfunction

  function automatic logic [FEAT_W-1:0] max2(input logic [FEAT_W-1:0] a,
                                             input logic [FEAT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_conv3x3_sobel.sv
// Line buffers, 3x3 sliding window and Sobel-X kernel MAC; emits the 30x30 valid conv map
// with map coordinates (centre row/col minus one).
module cnn_conv3x3_sobel
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     pix_valid_i,
  input  logic [PIX_W-1:0]         pix_i,
  output logic                     conv_valid_o,
  output logic [RW-1:0]            conv_row_o,
  output logic [CW-1:0]            conv_col_o,
  output logic signed [CONV_W-1:0] conv_data_o
);

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] win_q [3][3];
  logic             win_valid_q;
  logic [RW-1:0]    win_row_q;
  logic [CW-1:0]    win_col_q;

  logic                     conv_valid_q;
  logic [RW-1:0]            conv_row_q;
  logic [CW-1:0]            conv_col_q;
  logic signed [CONV_W-1:0] conv_data_q;
  logic signed [CONV_W-1:0] conv_sum_d;

  // lb0 holds the previous row, lb1 the row before; the window shifts left on every accepted pixel.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      win_valid_q <= pix_valid_i && (row_q >= RW'(2)) && (col_q >= CW'(2));
      if (pix_valid_i) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2]  <= lb1_q[col_q];
        win_q[1][2]  <= lb0_q[col_q];
        win_q[2][2]  <= pix_i;
        lb1_q[col_q] <= lb0_q[col_q];
        lb0_q[col_q] <= pix_i;
        win_row_q    <= row_q - RW'(2);
        win_col_q    <= col_q - CW'(2);
        if (col_q == CW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    conv_sum_d = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        conv_sum_d = conv_sum_d
                   + signed'({{(CONV_W-PIX_W){1'b0}}, win_q[r][c]}) * SOBEL_X[r][c];
      end
    end
  end

  // Kernel output register.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      conv_valid_q <= 1'b0;
      conv_row_q   <= '0;
      conv_col_q   <= '0;
      conv_data_q  <= '0;
    end else begin
      conv_valid_q <= win_valid_q;
      conv_row_q   <= win_row_q;
      conv_col_q   <= win_col_q;
      conv_data_q  <= conv_sum_d;
    end
  end

  assign conv_valid_o = conv_valid_q;
  assign conv_row_o   = conv_row_q;
  assign conv_col_o   = conv_col_q;
  assign conv_data_o  = conv_data_q;

endmodule

// File: rtl/cnn_top.sv
// Single-frame Sobel-X -> ReLU -> 2x2 max-pool -> column-weighted sum lane scorer.
// Pipeline: window -> conv -> pool -> MAC -> output, so the score lands 4 edges after the last pixel.
module cnn_top
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_signal,
  input  logic                    pixel_valid,
  input  logic [PIX_W-1:0]        pixel_in,
  output logic                    final_result_valid,
  output logic signed [ACC_W-1:0] final_lane_result
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int PCNT_W = $clog2(NPIX + 1);
  localparam int PCW    = $clog2(POOL_W);

  state_e              state_q, state_d;
  logic [PCNT_W-1:0]   pix_cnt_q;
  logic [1:0]          flush_cnt_q;
  logic                accept_s;
  logic                clr_s;
  logic                last_pix_s;

  logic                     conv_valid_s;
  logic [RW-1:0]            conv_row_s;
  logic [CW-1:0]            conv_col_s;
  logic signed [CONV_W-1:0] conv_data_s;
  logic [FEAT_W-1:0]        feat_s;
  logic [PCW-1:0]           pc_s;
  logic                     in_pool_s;

  logic [FEAT_W-1:0]        hold_q;
  logic [FEAT_W-1:0]        rowbuf_q [POOL_W];
  logic                     pool_valid_q;
  logic [FEAT_W-1:0]        pool_q;
  logic [PCW-1:0]           pool_col_q;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     valid_q;
  logic signed [ACC_W-1:0]  result_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; any start pulse (re)arms a frame from scratch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_signal ? RUN : IDLE;
      RUN: begin
        if (start_signal)    state_d = RUN;
        else if (last_pix_s) state_d = FLUSH;
        else                 state_d = RUN;
      end
      FLUSH: begin
        if (start_signal)              state_d = RUN;
        else if (flush_cnt_q == 2'd3)  state_d = DONE;
        else                           state_d = FLUSH;
      end
      DONE:    state_d = start_signal ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    clr_s = start_signal;
    case (state_q)
      RUN:     accept_s = pixel_valid & ~start_signal;
      default: accept_s = 1'b0;
    endcase
    last_pix_s = accept_s && (pix_cnt_q == PCNT_W'(NPIX - 1));
  end

  // Frame pixel counter and pipeline drain counter.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      pix_cnt_q   <= '0;
      flush_cnt_q <= 2'd0;
    end else begin
      if (accept_s) begin
        pix_cnt_q <= pix_cnt_q + PCNT_W'(1);
      end
      flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 2'd1 : 2'd0;
    end
  end

  cnn_conv3x3_sobel #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_conv (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_s),
    .pix_valid_i  (accept_s),
    .pix_i        (pixel_in),
    .conv_valid_o (conv_valid_s),
    .conv_row_o   (conv_row_s),
    .conv_col_o   (conv_col_s),
    .conv_data_o  (conv_data_s)
  );

  always_comb begin
    feat_s    = relu(conv_data_s);
    pc_s      = PCW'(conv_col_s >> 1);
    in_pool_s = ((conv_row_s >> 1) < RW'(POOL_W)) && ((conv_col_s >> 1) < CW'(POOL_W));
  end

  // Horizontal pair max in hold_q; even map rows park it in rowbuf, odd rows complete the 2x2.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      hold_q       <= '0;
      pool_valid_q <= 1'b0;
      pool_q       <= '0;
      pool_col_q   <= '0;
      for (int i = 0; i < POOL_W; i++) begin
        rowbuf_q[i] <= '0;
      end
    end else begin
      pool_valid_q <= 1'b0;
      if (conv_valid_s && in_pool_s) begin
        if (!conv_col_s[0]) begin
          hold_q <= feat_s;
        end else if (!conv_row_s[0]) begin
          rowbuf_q[pc_s] <= max2(hold_q, feat_s);
        end else begin
          pool_valid_q <= 1'b1;
          pool_q       <= max2(rowbuf_q[pc_s], max2(hold_q, feat_s));
          pool_col_q   <= pc_s;
        end
      end
    end
  end

  always_comb begin
    if (pool_valid_q) begin
      acc_d = acc_q + signed'(ACC_W'(pool_col_q) * ACC_W'(pool_q));
    end else begin
      acc_d = acc_q;
    end
  end

  // Column-weighted accumulator.
  always_ff @(posedge clk) begin
    if (rst || clr_s) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Output register: loads and pulses on entry to DONE, otherwise holds the last score.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (state_d == DONE) begin
      valid_q  <= 1'b1;
      result_q <= acc_q;
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign final_result_valid = valid_q;
  assign final_lane_result  = result_q;

endmodule

// File: tb/tb_cnn_top.sv
// Directed + randomized frames for cnn_top checked against an array-based reference score.
module tb_cnn_top;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_signal = 1'b0;
  logic               pixel_valid = 1'b0;
  logic [7:0]         pixel_in = 8'd0;
  logic               final_result_valid;
  logic signed [47:0] final_lane_result;

  int         vectors = 0;
  int         miscompares = 0;
  int         pulse_cnt = 0;
  logic [7:0] img [1024];

  always #5 clk = ~clk;

  cnn_top dut (
    .clk                (clk),
    .rst                (rst),
    .start_signal       (start_signal),
    .pixel_valid        (pixel_valid),
    .pixel_in           (pixel_in),
    .final_result_valid (final_result_valid),
    .final_lane_result  (final_lane_result)
  );

  always @(negedge clk) begin
    if (final_result_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 0 raster ramp, 1 4*col, 2 constant 200, 3 255-4*col, 4 random
  task automatic fill_img(input int kind);
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        case (kind)
          0:       img[r*32+c] = 8'((32*r + c) % 256);
          1:       img[r*32+c] = 8'(4*c);
          2:       img[r*32+c] = 8'd200;
          3:       img[r*32+c] = 8'(255 - 4*c);
          default: img[r*32+c] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  function automatic int px(input int r, input int c);
    return int'(img[r*32+c]);
  endfunction

  // Straight from the definition: conv over centres 1..30, ReLU, 2x2 max, sum of col*P.
  function automatic logic signed [63:0] ref_score();
    int f [30][30];
    int s, g, m;
    s = 0;
    for (int r = 1; r <= 30; r++) begin
      for (int c = 1; c <= 30; c++) begin
        g = (px(r-1, c+1) - px(r-1, c-1)) + 2*(px(r, c+1) - px(r, c-1)) + (px(r+1, c+1) - px(r+1, c-1));
        f[r-1][c-1] = (g < 0) ? 0 : g;
      end
    end
    for (int pr = 0; pr < 15; pr++) begin
      for (int pc = 0; pc < 15; pc++) begin
        m = f[2*pr][2*pc];
        if (f[2*pr][2*pc+1] > m)   m = f[2*pr][2*pc+1];
        if (f[2*pr+1][2*pc] > m)   m = f[2*pr+1][2*pc];
        if (f[2*pr+1][2*pc+1] > m) m = f[2*pr+1][2*pc+1];
        s += pc * m;
      end
    end
    return 64'(s);
  endfunction

  // mode 0 continuous, 1 alternate valid, 2 random idle gaps
  task automatic send_pixels(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = img[i];
      tick();
      pixel_valid = 1'b0;
      if (i < n - 1) begin
        if (mode == 1) begin
          pixel_in = 8'hFF;
          tick();
        end else if (mode == 2) begin
          repeat ($urandom_range(0, 2)) begin
            pixel_in = 8'($urandom_range(0, 255));
            tick();
          end
        end
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int mode, input bit junk, input logic signed [63:0] exp);
    int p0;
    p0 = pulse_cnt;
    start_signal = 1'b1;
    pixel_valid  = junk;
    pixel_in     = 8'hA5;
    tick();
    start_signal = 1'b0;
    pixel_valid  = 1'b0;
    send_pixels(1024, mode);
    chk({tag, "_v0"}, 64'(final_result_valid), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) begin
        chk({tag, "_vld"}, 64'(final_result_valid), 64'd1);
        chk({tag, "_res"}, final_lane_result, exp);
      end else begin
        chk($sformatf("%s_v%0d", tag, k), 64'(final_result_valid), 64'd0);
      end
    end
    chk({tag, "_hold"}, final_lane_result, exp);
    chk({tag, "_pulses"}, 64'(pulse_cnt - p0), 64'd1);
  endtask

  initial begin
    int p0;
    logic signed [63:0] exp_s;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_vld", 64'(final_result_valid), 64'd0);
    chk("rst_res", final_lane_result, 64'd0);
    rst = 1'b0;
    tick();

    fill_img(0);
    run_frame("raster", 0, 1'b0, 64'sd12600);
    fill_img(1);
    run_frame("hramp", 0, 1'b0, 64'sd50400);
    fill_img(2);
    run_frame("const", 0, 1'b0, 64'sd0);
    fill_img(3);
    run_frame("desc", 0, 1'b0, 64'sd0);
    fill_img(1);
    run_frame("toggle", 1, 1'b0, 64'sd50400);

    // Abort a ramp frame part way, then a full constant frame: one pulse, score 0.
    p0 = pulse_cnt;
    fill_img(1);
    start_signal = 1'b1;
    tick();
    start_signal = 1'b0;
    send_pixels(500, 0);
    fill_img(2);
    run_frame("abort", 0, 1'b0, 64'sd0);
    chk("abort_total_pulses", 64'(pulse_cnt - p0), 64'd1);

    fill_img(4);
    exp_s = ref_score();
    run_frame("rand_gap_junk", 2, 1'b1, exp_s);
    fill_img(4);
    exp_s = ref_score();
    run_frame("rand", 0, 1'b0, exp_s);

    fill_img(1);
    run_frame("pre_rst", 0, 1'b0, 64'sd50400);

    // Reset mid-frame, then idle pixels that must be ignored.
    p0 = pulse_cnt;
    start_signal = 1'b1;
    tick();
    start_signal = 1'b0;
    send_pixels(300, 0);
    rst = 1'b1;
    tick();
    chk("midrst_vld", 64'(final_result_valid), 64'd0);
    chk("midrst_res", final_lane_result, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'($urandom_range(0, 255));
      tick();
    end
    pixel_valid = 1'b0;
    repeat (6) tick();
    chk("midrst_pulses", 64'(pulse_cnt - p0), 64'd0);
    chk("midrst_res_hold", final_lane_result, 64'd0);
    run_frame("post_rst", 0, 1'b0, 64'sd50400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
